uart_tx_sched: RTL and testbench

//  Shares the single UART transmitter between two byte producers: port 0 = CPU console MMIO,

---
 rtl/uart_tx_sched_if.sv | 41 ++++
 rtl/uart_tx_sched.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// ============================================================================
// Module      : uart_tx_sched_if
// Description : Bundles the producer-side and UartTx-side signals of the
//               shared UART transmit scheduler.
//               slave  modport : scheduler view (producers in, UartTx out)
//               master modport : environment view (drives producers/READY)
//   p0_we/p0_data/p0_full : console port write strobe, byte, FIFO full
//   p1_we/p1_data/p1_full : loader/debug port write strobe, byte, FIFO full
//   ovf                   : sticky overflow flags, bit n for port n
//   tx_data/tx_we         : byte and one-cycle write strobe to UartTx
//   tx_ready              : UartTx READY
//   grant                 : port whose byte is currently in flight
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_sched_if;
  logic       p0_we;
  logic [7:0] p0_data;
  logic       p0_full;
  logic       p1_we;
  logic [7:0] p1_data;
  logic       p1_full;
  logic [1:0] ovf;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_ready;
  logic       grant;

  modport slave (
    input  p0_we, p0_data, p1_we, p1_data, tx_ready,
    output p0_full, p1_full, ovf, tx_data, tx_we, grant
  );

  modport master (
    output p0_we, p0_data, p1_we, p1_data, tx_ready,
    input  p0_full, p1_full, ovf, tx_data, tx_we, grant
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module      : uart_tx_sched
// Description : Shares one UART transmitter between two byte producers
//               (port 0 = CPU console, port 1 = loader/debug status). Each
//               port has a small FIFO; a round-robin scheduler hands bytes
//               one at a time to UartTx and keeps a single byte in flight.
// Ports       : clk, rst (synchronous, active high)
//               bus (uart_tx_sched_if.slave): producer writes, full flags,
//               sticky overflow, UartTx DATA/WE/READY and current grant.
// Parameters  : DEPTH_LOG - log2 of per-port FIFO depth
// Macro       : UART_TX_CRLF_EN - when defined, a head byte 8'h0A is sent
//               as 8'h0D followed by 8'h0A from the same port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_sched #(
  parameter int DEPTH_LOG = 2
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_sched_if.slave bus
);

  localparam int unsigned            c_depth     = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0]     c_depth_cnt = c_depth[DEPTH_LOG:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [1:0] w_we;
  logic [7:0] w_wdata [2];
  logic [7:0] w_head  [2];
  logic [1:0] w_empty;
  logic [1:0] w_full;
  logic [1:0] w_pop;

  logic       w_issue;
  logic       w_port;
  logic       w_rr_port;
  logic [7:0] w_issue_data;

  logic       r_tx_we;
  logic [7:0] r_tx_data;
  logic       r_grant;
  logic       r_last;
  logic [1:0] r_ovf;

  assign w_we       = {bus.p1_we, bus.p0_we};
  assign w_wdata[0] = bus.p0_data;
  assign w_wdata[1] = bus.p1_data;

  // ---------------------------------------------------------------- FIFOs
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [7:0]           r_mem [c_depth];
    logic [DEPTH_LOG-1:0] r_wr_ptr;
    logic [DEPTH_LOG-1:0] r_rd_ptr;
    logic [DEPTH_LOG:0]   r_count;
    logic                 w_push;

    assign w_full[gi]  = (r_count == c_depth_cnt);
    assign w_empty[gi] = (r_count == '0);
    assign w_push      = w_we[gi] & ~w_full[gi];
    assign w_head[gi]  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_wdata[gi];
      end
    end

    // Pointers wrap naturally at DEPTH_LOG bits.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop[gi]) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_pop[gi]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Both non-empty: alternate away from the last served port.
  // Otherwise serve whichever one holds data.
  assign w_rr_port = (~w_empty[0] & ~w_empty[1]) ? ~r_last : ~w_empty[1];

`ifdef UART_TX_CRLF_EN
  logic [1:0] r_cr_sent;
  logic [1:0] w_cr_set;
  logic [1:0] w_cr_clr;
`endif

  // ------------------------------------------------------ scheduler FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_port       = 1'b0;
    w_pop        = 2'b00;
    w_issue_data = 8'h00;
`ifdef UART_TX_CRLF_EN
    w_cr_set     = 2'b00;
    w_cr_clr     = 2'b00;
`endif
    case (r_state)
      IDLE: begin
        if (bus.tx_ready && (w_empty != 2'b11)) begin
          w_issue      = 1'b1;
          w_state_next = WAIT_LO;
`ifdef UART_TX_CRLF_EN
          // A port that already sent its CR owns the next slot for the LF.
          if (r_cr_sent[0]) begin
            w_port = 1'b0;
          end else if (r_cr_sent[1]) begin
            w_port = 1'b1;
          end else begin
            w_port = w_rr_port;
          end
          if ((w_head[w_port] == 8'h0A) && !r_cr_sent[w_port]) begin
            w_issue_data     = 8'h0D;
            w_cr_set[w_port] = 1'b1;
          end else begin
            w_issue_data     = w_head[w_port];
            w_pop[w_port]    = 1'b1;
            w_cr_clr[w_port] = 1'b1;
          end
`else
          w_port        = w_rr_port;
          w_issue_data  = w_head[w_port];
          w_pop[w_port] = 1'b1;
`endif
        end
      end
      WAIT_LO: begin
        if (!bus.tx_ready) begin
          w_state_next = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.tx_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // -------------------------------------------------- registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_we   <= 1'b0;
      r_tx_data <= 8'h00;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_ovf     <= 2'b00;
    end else begin
      r_tx_we <= w_issue;
      if (w_issue) begin
        r_tx_data <= w_issue_data;
        r_grant   <= w_port;
        r_last    <= w_port;
      end
      // Full is the pre-edge state, so a same-cycle pop never rescues it.
      r_ovf <= r_ovf | (w_we & w_full);
    end
  end

`ifdef UART_TX_CRLF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cr_sent <= 2'b00;
    end else begin
      r_cr_sent <= (r_cr_sent | w_cr_set) & ~w_cr_clr;
    end
  end
`endif

  assign bus.p0_full = w_full[0];
  assign bus.p1_full = w_full[1];
  assign bus.ovf     = r_ovf;
  assign bus.tx_data = r_tx_data;
  assign bus.tx_we   = r_tx_we;
  assign bus.grant   = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Self-checking bench for uart_tx_sched. A queue-based model
//               predicts FIFO contents, scheduling order and UartTx
//               handshake; directed scenarios plus randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_sched_if bus ();

  uart_tx_sched #(.DEPTH_LOG(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  bit cmp_en    = 1'b0;
  bit auto_uart = 1'b0;

  // Behavioural model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [1:0] m_ovf   = 2'b00;
  bit         m_last  = 1'b1;
  bit         m_busy  = 1'b0;
  bit         m_low   = 1'b0;
  bit [1:0]   m_cr    = 2'b00;
  bit         e_we    = 1'b0;
  logic [7:0] e_data  = 8'h00;
  bit         e_grant = 1'b0;

  logic [7:0] tx_log[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Model: advance one clock using the inputs present at the edge.
  always @(posedge clk) begin
    bit         f0, f1, p, pop;
    logic [7:0] hd, d;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_ovf = 2'b00; m_last = 1'b1; m_busy = 1'b0; m_low = 1'b0; m_cr = 2'b00;
      e_we = 1'b0; e_data = 8'h00; e_grant = 1'b0;
    end else begin
      f0 = (q0.size() == 4);
      f1 = (q1.size() == 4);
      e_we = 1'b0;
      if (!m_busy && bus.tx_ready && (q0.size() != 0 || q1.size() != 0)) begin
        if (m_cr[0])      p = 1'b0;
        else if (m_cr[1]) p = 1'b1;
        else if (q0.size() != 0 && q1.size() != 0) p = !m_last;
        else p = (q0.size() == 0);
        hd  = p ? q1[0] : q0[0];
        d   = hd;
        pop = 1'b1;
`ifdef UART_TX_CRLF_EN
        if (hd == 8'h0A && !m_cr[p]) begin
          d = 8'h0D; pop = 1'b0; m_cr[p] = 1'b1;
        end else begin
          m_cr[p] = 1'b0;
        end
`endif
        if (pop) begin
          if (p) void'(q1.pop_front());
          else   void'(q0.pop_front());
        end
        e_we = 1'b1; e_data = d; e_grant = p; m_last = p;
        m_busy = 1'b1; m_low = 1'b0;
      end else if (m_busy) begin
        if (!m_low) begin
          if (!bus.tx_ready) m_low = 1'b1;
        end else if (bus.tx_ready) begin
          m_busy = 1'b0;
        end
      end
      if (bus.p0_we) begin
        if (f0) m_ovf[0] = 1'b1; else q0.push_back(bus.p0_data);
      end
      if (bus.p1_we) begin
        if (f1) m_ovf[1] = 1'b1; else q1.push_back(bus.p1_data);
      end
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tx_we",   {31'd0, bus.tx_we}, {31'd0, e_we});
      chk("tx_data", {24'd0, bus.tx_data}, {24'd0, e_data});
      chk("grant",   {31'd0, bus.grant}, {31'd0, e_grant});
      chk("p0_full", {31'd0, bus.p0_full}, {31'd0, q0.size() == 4});
      chk("p1_full", {31'd0, bus.p1_full}, {31'd0, q1.size() == 4});
      chk("ovf",     {30'd0, bus.ovf}, {30'd0, m_ovf});
      if (bus.tx_we) tx_log.push_back(bus.tx_data);
    end
  end

  // UartTx stand-in: drops READY one cycle after WE, busy 1..4 cycles.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (auto_uart && bus.tx_we) begin
        @(posedge clk); #2;
        bus.tx_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #2;
        bus.tx_ready = 1'b1;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic clear_inputs();
    bus.p0_we = 1'b0; bus.p0_data = 8'h00;
    bus.p1_we = 1'b0; bus.p1_data = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    chk("wait_log_count", tx_log.size(), n);
  endtask

  task automatic check_seq(input string name);
    chk({name, "_len"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
      chk(name, {24'd0, tx_log[i]}, {24'd0, exp_q[i]});
    end
  endtask

  task automatic wr(input bit w0, input logic [7:0] d0, input bit w1, input logic [7:0] d1);
    bus.p0_we = w0; bus.p0_data = d0;
    bus.p1_we = w1; bus.p1_data = d1;
    cyc(1);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    bus.tx_ready = 1'b1;
    @(posedge clk); #2;
    cmp_en = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Reset values
    chk("rst_tx_we",   {31'd0, bus.tx_we}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_grant",   {31'd0, bus.grant}, 32'd0);
    chk("rst_ovf",     {30'd0, bus.ovf}, 32'd0);

    // 1: latency t+2
    bus.p0_we = 1'b1; bus.p0_data = 8'h41;
    cyc(1);
    clear_inputs();
    chk("t1_we_t1", {31'd0, bus.tx_we}, 32'd0);
    cyc(1);
    chk("t1_we_t2",   {31'd0, bus.tx_we}, 32'd1);
    chk("t1_data_t2", {24'd0, bus.tx_data}, 32'h41);
    chk("t1_grant",   {31'd0, bus.grant}, 32'd0);
    cyc(1);
    bus.tx_ready = 1'b0; cyc(2);
    bus.tx_ready = 1'b1; cyc(3);

    // 2: round-robin order
    do_reset();
    auto_uart = 1'b1;
    tx_log.delete();
    wr(1'b1, 8'h41, 1'b1, 8'h61);
    wr(1'b1, 8'h42, 1'b1, 8'h62);
    wait_log(4, 100);
    exp_q = {8'h41, 8'h61, 8'h42, 8'h62};
    check_seq("t2_order");
    cyc(10);

    // 3: overflow on port 1 with READY low
    auto_uart = 1'b0;
    do_reset();
    bus.tx_ready = 1'b0;
    tx_log.delete();
    for (int i = 0; i < 5; i++) wr(1'b0, 8'h00, 1'b1, 8'h51 + 8'(i));
    chk("t3_p1_full", {31'd0, bus.p1_full}, 32'd1);
    chk("t3_ovf",     {30'd0, bus.ovf}, 32'd2);
    bus.tx_ready = 1'b1;
    auto_uart = 1'b1;
    wait_log(4, 100);
    exp_q = {8'h51, 8'h52, 8'h53, 8'h54};
    check_seq("t3_drain");
    cyc(10);

    // 4: late READY handshake
    auto_uart = 1'b0;
    do_reset();
    bus.tx_ready = 1'b1;
    tx_log.delete();
    wr(1'b1, 8'hA1, 1'b0, 8'h00);
    wr(1'b1, 8'hA2, 1'b0, 8'h00);
    cyc(8);
    chk("t4_ready_held_high", tx_log.size(), 1);
    bus.tx_ready = 1'b0;
    cyc(3);
    chk("t4_ready_low", tx_log.size(), 1);
    bus.tx_ready = 1'b1;
    wait_log(2, 10);
    exp_q = {8'hA1, 8'hA2};
    check_seq("t4_seq");
    cyc(1);
    bus.tx_ready = 1'b0; cyc(2);
    bus.tx_ready = 1'b1; cyc(3);

    // 5: LF handling
    do_reset();
    auto_uart = 1'b1;
    tx_log.delete();
    wr(1'b1, 8'h0A, 1'b1, 8'h31);
`ifdef UART_TX_CRLF_EN
    wait_log(3, 100);
    exp_q = {8'h0D, 8'h0A, 8'h31};
`else
    wait_log(2, 100);
    exp_q = {8'h0A, 8'h31};
`endif
    check_seq("t5_crlf");
    cyc(10);

    // 6: reset in WAIT_HI with bytes queued
    auto_uart = 1'b0;
    do_reset();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) wr(1'b1, 8'hC1 + 8'(i), 1'b0, 8'h00);
    bus.tx_ready = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk("t6_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("t6_p0_full", {31'd0, bus.p0_full}, 32'd0);
    chk("t6_grant",   {31'd0, bus.grant}, 32'd0);
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    tx_log.delete();
    cyc(20);
    chk("t6_no_tx_after_rst", tx_log.size(), 0);

    // Randomized traffic
    do_reset();
    auto_uart = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.p0_we   = ($urandom_range(0, 3) == 0);
      bus.p0_data = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
      bus.p1_we   = ($urandom_range(0, 3) == 0);
      bus.p1_data = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
      rst         = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    clear_inputs();
    rst = 1'b0;
    cyc(200);
    chk("rand_drained_p0", q0.size(), 0);
    chk("rand_drained_p1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
